// File: rtl/tpu_isa_pkg.sv
// Shared TPU instruction-set constants and the sequencer state type.
// The control unit and the sequencer both decode opcodes from this package.
package tpu_isa_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 3;

    localparam logic [OPC_W-1:0] OP_LOAD      = 3'b000;
    localparam logic [OPC_W-1:0] OP_BROADCAST = 3'b001;
    localparam logic [OPC_W-1:0] OP_MATMUL    = 3'b010;
    localparam logic [OPC_W-1:0] OP_STORE     = 3'b011;
    localparam logic [OPC_W-1:0] OP_NOP       = 3'b100;
    localparam logic [OPC_W-1:0] OP_HALT      = 3'b111;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h8000;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_FETCH,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_HALTED
    } seq_state_t;

    function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Host-programmed instruction store: one synchronous write port and one
// registered read port. Contents are deliberately not reset.
module instr_mem
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/issue stage: walks instruction memory from address 0 after start,
// issues each word for one cycle, then waits for op_done before the next fetch.
module instr_sequencer
    import tpu_isa_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic               start,
    input  logic               op_done,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    seq_state_t         state, state_nxt;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [INSTR_W-1:0] instr_nxt;
    logic               valid_nxt;
    logic [INSTR_W-1:0] rd_data;
    logic               mem_we;
    logic               mem_re;
    logic               idle_like;
    logic               at_end;

    assign idle_like = (state == SEQ_IDLE) || (state == SEQ_HALTED);
    assign at_end    = (pc == ADDR_W'(DEPTH - 1));
    assign mem_we    = prog_we && idle_like;
    assign mem_re    = (state == SEQ_FETCH);

    instr_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .re    (mem_re),
        .raddr (pc),
        .rdata (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SEQ_IDLE;
            pc          <= '0;
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
            instr_valid <= valid_nxt;
        end
    end

    // Outside the single ISSUE edge the output always falls back to NOP.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = NOP_INSTR;
        valid_nxt = 1'b0;
        unique case (state)
            SEQ_IDLE, SEQ_HALTED: begin
                if (start) begin
                    state_nxt = SEQ_FETCH;
                    pc_nxt    = '0;
                end
            end
            SEQ_FETCH: begin
                state_nxt = SEQ_ISSUE;
            end
            SEQ_ISSUE: begin
                if (opcode_of(rd_data) == OP_HALT) begin
                    state_nxt = SEQ_HALTED;
                end else begin
                    instr_nxt = rd_data;
                    valid_nxt = 1'b1;
                    state_nxt = SEQ_WAIT;
                end
            end
            SEQ_WAIT: begin
                if (op_done) begin
                    if (at_end) begin
                        state_nxt = SEQ_HALTED;
                    end else begin
                        pc_nxt    = pc + ADDR_W'(1);
                        state_nxt = SEQ_FETCH;
                    end
                end
            end
            default: begin
                state_nxt = SEQ_IDLE;
            end
        endcase
    end

    assign busy   = (state == SEQ_FETCH) || (state == SEQ_ISSUE) || (state == SEQ_WAIT);
    assign halted = (state == SEQ_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer: a reference instruction memory yields the
// expected issue stream, and issue timing follows from when op_done was driven.
module tb_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam logic [15:0] NOP = 16'h8000;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [15:0]   prog_data;
    logic          start;
    logic          op_done;
    logic [15:0]   instruction;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    instr_sequencer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .op_done     (op_done),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .busy        (busy),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int edge_n = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [15:0] exp_q [$];
    int          exp_pc_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic check_idle(input string tag, input logic [AW-1:0] exp_pc);
        check({tag, "_instr"}, 32'(instruction), 32'(NOP));
        check({tag, "_valid"}, 32'(instr_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pc"}, 32'(pc), 32'(exp_pc));
    endtask

    task automatic write_word(input int addr, input logic [15:0] data);
        prog_we   = 1'b1;
        prog_addr = AW'(addr);
        prog_data = data;
        ref_mem[addr] = data;
        step();
        prog_we = 1'b0;
    endtask

    // Run from start to HALTED, checking order, pc and timing of every issue.
    task automatic run(input int min_d, input int max_d, input bit hold, input bit poke,
                       input bit wr0, input logic [15:0] wr_data, input bit abort_first);
        int due;
        int done_at;
        int budget;
        int halt_pc;
        bit poked;
        poked   = 1'b0;
        done_at = -1;
        halt_pc = DEPTH - 1;
        if (wr0) ref_mem[0] = wr_data;
        exp_q.delete();
        exp_pc_q.delete();
        for (int a = 0; a < DEPTH; a++) begin
            if (ref_mem[a][15:13] == 3'b111) begin
                halt_pc = a;
                break;
            end
            exp_q.push_back(ref_mem[a]);
            exp_pc_q.push_back(a);
        end
        start   = 1'b1;
        op_done = hold;
        if (wr0) begin
            prog_we   = 1'b1;
            prog_addr = '0;
            prog_data = wr_data;
        end
        due = edge_n + 3;
        step();
        start   = 1'b0;
        prog_we = 1'b0;
        budget  = 0;
        while (!halted && budget < 400) begin
            budget++;
            check("busy_run", 32'(busy), 1);
            if (instr_valid) begin
                check("issue_time", 32'(edge_n), 32'(due));
                check("halt_issued", 32'(instruction[15:13] == 3'b111), 0);
                if (exp_q.size() == 0) begin
                    check("extra_issue", 32'(instruction), 32'(NOP));
                end else begin
                    check("instr", 32'(instruction), 32'(exp_q.pop_front()));
                    check("issue_pc", 32'(pc), 32'(exp_pc_q.pop_front()));
                end
                if (abort_first) begin
                    rst     = 1'b1;
                    op_done = 1'b1;
                    step();
                    rst     = 1'b0;
                    op_done = 1'b0;
                    check_idle("after_rst", '0);
                    check("after_rst_halted", 32'(halted), 0);
                    for (int i = 0; i < 5; i++) begin
                        step();
                        check_idle("rst_quiet", '0);
                    end
                    return;
                end
                done_at = edge_n + $urandom_range(min_d, max_d);
                if (poke && !poked) begin
                    poked     = 1'b1;
                    prog_we   = 1'b1;
                    prog_addr = '0;
                    prog_data = 16'hE000;
                    start     = 1'b1;
                end
                if (hold) due = edge_n + 3;
            end else begin
                check("nop_between", 32'(instruction), 32'(NOP));
                if (edge_n == due && exp_q.size() != 0) check("issue_missing", 0, 1);
            end
            if (!hold) begin
                op_done = (edge_n == done_at);
                if (op_done) due = edge_n + 3;
            end
            step();
            prog_we = 1'b0;
            start   = 1'b0;
        end
        op_done = 1'b0;
        check("halted", 32'(halted), 1);
        check("halt_pc", 32'(pc), 32'(halt_pc));
        check("halt_busy", 32'(busy), 0);
        check("halt_valid", 32'(instr_valid), 0);
        check("unissued", 32'(exp_q.size()), 0);
    endtask

    initial begin
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        start = 1'b0; op_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_idle("reset_idle", '0);
            check("reset_halted", 32'(halted), 0);
            step();
        end

        // Four ops then HALT, op_done three cycles after each issue.
        write_word(0, 16'h0000);
        write_word(1, 16'h2000);
        write_word(2, 16'h4000);
        write_word(3, 16'h6000);
        write_word(4, 16'hE000);
        run(3, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Full memory with op_done held high: run to the end of memory.
        for (int a = 0; a < DEPTH; a++) write_word(a, 16'h4000);
        run(0, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);

        // Random programs, occasional HALT, random op_done delays.
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                logic [15:0] w;
                w = 16'($urandom_range(0, 16'hFFFF));
                if (w[15:13] == 3'b111 && $urandom_range(0, 3) != 0) w[15] = 1'b0;
                write_word(a, w);
            end
            run(0, 4, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        end

        // Write/start while busy are ignored; rerun shows word 0 unchanged.
        for (int a = 0; a < DEPTH; a++) write_word(a, 16'h2000 + 16'(a));
        run(0, 2, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        run(0, 1, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        // Start together with a write to address 0.
        run(0, 2, 1'b0, 1'b0, 1'b1, 16'h6000, 1'b0);

        // Reset in WAIT with op_done high, then restart.
        run(0, 0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        run(1, 3, 1'b0, 1'b0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
